// File: rtl/temporizador_estados_pkg.sv
// rtl/temporizador_estados_pkg.sv - shared state codes and timer FSM types
// Holds the controller state-code constants (shared with the coffee-machine
// controller), the internal timer FSM encoding and two small helpers that
// classify a state code.
package temporizador_estados_pkg;

    localparam int COD_W = 3;

    localparam logic [COD_W-1:0] ESPERANDO     = 3'b000;
    localparam logic [COD_W-1:0] ESCOLHENDO    = 3'b001;
    localparam logic [COD_W-1:0] SENSORES      = 3'b010;
    localparam logic [COD_W-1:0] PAGAMENTO     = 3'b011;
    localparam logic [COD_W-1:0] ERRO_VALOR    = 3'b100;
    localparam logic [COD_W-1:0] PRESSURIZACAO = 3'b101;
    localparam logic [COD_W-1:0] AQUECIMENTO   = 3'b110;
    localparam logic [COD_W-1:0] PRONTO        = 3'b111;

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        CONTANDO = 2'b01,
        EXPIRADO = 2'b10
    } fase_t;

    // Codes 011..111 are the timed states.
    function automatic logic eh_temporizado(input logic [COD_W-1:0] cod);
        return cod >= PAGAMENTO;
    endfunction

    // One-hot pulse vector {PRO, AQU, PRE, ERRO, PAG} for a timed code.
    function automatic logic [4:0] pulso_de(input logic [COD_W-1:0] cod);
        logic [4:0] v;
        case (cod)
            PAGAMENTO:     v = 5'b00001;
            ERRO_VALOR:    v = 5'b00010;
            PRESSURIZACAO: v = 5'b00100;
            AQUECIMENTO:   v = 5'b01000;
            PRONTO:        v = 5'b10000;
            default:       v = 5'b00000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/temporizador_estados_if.sv
// rtl/temporizador_estados_if.sv - controller <-> timer signal bundle
// master: controller side (drives ESTADO_COD, receives pulses/display data)
// slave : timer side (samples ESTADO_COD, drives TIMER_*, RESTANTE, ATIVO)
interface temporizador_estados_if
    import temporizador_estados_pkg::*;
#(
    parameter int CNT_W = 6
) ();

    logic [COD_W-1:0] ESTADO_COD;
    logic             TIMER_PAG;
    logic             TIMER_ERRO;
    logic             TIMER_PRE;
    logic             TIMER_AQU;
    logic             TIMER_PRO;
    logic [CNT_W-1:0] RESTANTE;
    logic             ATIVO;

    modport master (
        output ESTADO_COD,
        input  TIMER_PAG, TIMER_ERRO, TIMER_PRE, TIMER_AQU, TIMER_PRO,
        input  RESTANTE, ATIVO
    );

    modport slave (
        input  ESTADO_COD,
        output TIMER_PAG, TIMER_ERRO, TIMER_PRE, TIMER_AQU, TIMER_PRO,
        output RESTANTE, ATIVO
    );

endinterface

// File: rtl/temporizador_estados_divisor_tick.sv
// rtl/temporizador_estados_divisor_tick.sv - prescaler emitting one tick per PRESC cycles
// CLK      clock, rising edge
// RST_N    asynchronous active-low reset
// LIMPA    synchronous clear (wins over HABILITA)
// HABILITA count enable
// TICK     high in the cycle where the enabled counter wraps
module divisor_tick #(
    parameter int PRESC   = 50000000,
    parameter int PRESC_W = 26
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic LIMPA,
    input  logic HABILITA,
    output logic TICK
);

    logic [PRESC_W-1:0] cnt;
    logic               no_topo;

    assign no_topo = (cnt == PRESC_W'(PRESC - 1));
    assign TICK    = HABILITA && !LIMPA && no_topo;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (LIMPA) begin
            cnt <= '0;
        end else if (HABILITA) begin
            cnt <= no_topo ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/temporizador_estados.sv
// rtl/temporizador_estados.sv - per-state timeout generator for the coffee-machine controller
// CLK   clock, rising edge
// RST_N asynchronous active-low reset
// tmr   slave side of temporizador_estados_if: ESTADO_COD in;
//       TIMER_PAG/ERRO/PRE/AQU/PRO one-cycle timeout pulses, RESTANTE ticks
//       left in the current timed state, ATIVO high while counting (all registered)
module temporizador_estados
    import temporizador_estados_pkg::*;
#(
    parameter int PRESC   = 50000000,
    parameter int PRESC_W = 26,
    parameter int CNT_W   = 6,
    parameter int T_PAG   = 30,
    parameter int T_ERRO  = 3,
    parameter int T_PRE   = 5,
    parameter int T_AQU   = 10,
    parameter int T_PRO   = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    temporizador_estados_if.slave tmr
);

    logic [COD_W-1:0] est_reg;
    fase_t            fase, fase_nxt;
    logic [CNT_W-1:0] ticks, ticks_nxt;
    logic [CNT_W-1:0] restante, restante_nxt;
    logic [CNT_W-1:0] lim_atual, lim_novo, lim_sel;
    logic [4:0]       pulso, pulso_nxt;
    logic             ativo, ativo_nxt;
    logic             mudou;
    logic             tick;

    // A zero limit would never expire, so it is promoted to one tick.
    function automatic logic [CNT_W-1:0] limite(input logic [COD_W-1:0] cod);
        int t;
        case (cod)
            PAGAMENTO:     t = T_PAG;
            ERRO_VALOR:    t = T_ERRO;
            PRESSURIZACAO: t = T_PRE;
            AQUECIMENTO:   t = T_AQU;
            PRONTO:        t = T_PRO;
            default:       t = 1;
        endcase
        if (t == 0) t = 1;
        return CNT_W'(t);
    endfunction

    assign mudou     = (tmr.ESTADO_COD != est_reg);
    assign lim_atual = limite(est_reg);
    assign lim_novo  = limite(tmr.ESTADO_COD);

    divisor_tick #(
        .PRESC   (PRESC),
        .PRESC_W (PRESC_W)
    ) u_divisor (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .LIMPA    (mudou),
        .HABILITA (fase == CONTANDO),
        .TICK     (tick)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            est_reg  <= ESPERANDO;
            fase     <= OCIOSO;
            ticks    <= '0;
            pulso    <= '0;
            restante <= '0;
            ativo    <= 1'b0;
        end else begin
            est_reg  <= tmr.ESTADO_COD;
            fase     <= fase_nxt;
            ticks    <= ticks_nxt;
            pulso    <= pulso_nxt;
            restante <= restante_nxt;
            ativo    <= ativo_nxt;
        end
    end

    // A state change takes priority over an expiry on the same edge, so a
    // pulse is only produced while the code is still the one being timed.
    always_comb begin
        fase_nxt  = fase;
        ticks_nxt = ticks;
        pulso_nxt = '0;
        if (mudou) begin
            ticks_nxt = '0;
            fase_nxt  = eh_temporizado(tmr.ESTADO_COD) ? CONTANDO : OCIOSO;
        end else if (fase == CONTANDO && tick) begin
            if (ticks >= lim_atual - 1'b1) begin
                ticks_nxt = lim_atual;
                fase_nxt  = EXPIRADO;
                pulso_nxt = pulso_de(est_reg);
            end else begin
                ticks_nxt = ticks + 1'b1;
            end
        end
        lim_sel      = mudou ? lim_novo : lim_atual;
        ativo_nxt    = (fase_nxt == CONTANDO);
        restante_nxt = ativo_nxt ? (lim_sel - ticks_nxt) : '0;
    end

    assign tmr.TIMER_PAG  = pulso[0];
    assign tmr.TIMER_ERRO = pulso[1];
    assign tmr.TIMER_PRE  = pulso[2];
    assign tmr.TIMER_AQU  = pulso[3];
    assign tmr.TIMER_PRO  = pulso[4];
    assign tmr.RESTANTE   = restante;
    assign tmr.ATIVO      = ativo;

endmodule

// File: tb/tb_temporizador_estados.sv
// tb/tb_temporizador_estados.sv - self-checking bench for temporizador_estados
module tb_temporizador_estados;
    import temporizador_estados_pkg::*;

    localparam int PRESC = 4;
    localparam int CNT_W = 6;

    logic CLK;
    logic RST_N;

    temporizador_estados_if #(.CNT_W(CNT_W)) bus ();

    temporizador_estados #(
        .PRESC   (PRESC),
        .PRESC_W (3),
        .CNT_W   (CNT_W),
        .T_PAG   (3),
        .T_ERRO  (2),
        .T_PRE   (1),
        .T_AQU   (2),
        .T_PRO   (1)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .tmr   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] cod;
        int         hold;
        int         linha;
        int         atraso;
    } vec_t;

    typedef struct {
        int linha;
        int borda;
    } esp_t;

    vec_t tab [12];
    esp_t fila [$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   e0;

    task automatic conferir(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nome, got, exp, edge_n);
        end
    endtask

    // Drive a code at a negedge; the following posedge is the change edge.
    // The code stays for 'hold' posedges before the next call changes it.
    task automatic aplicar(input logic [2:0] cod, input int hold, input int linha, input int atraso);
        @(negedge CLK);
        bus.ESTADO_COD = cod;
        if (linha >= 0) fila.push_back('{linha, edge_n + 1 + atraso});
        repeat (hold - 1) @(negedge CLK);
    endtask

    // Every cycle, the pulse vector must equal the scoreboard's expectation.
    initial begin
        logic [4:0] got, exp;
        forever begin
            @(posedge CLK);
            edge_n++;
            #1;
            got = {bus.TIMER_PRO, bus.TIMER_AQU, bus.TIMER_PRE, bus.TIMER_ERRO, bus.TIMER_PAG};
            exp = '0;
            if (fila.size() > 0 && fila[0].borda == edge_n) begin
                exp = 5'(1 << fila[0].linha);
                void'(fila.pop_front());
            end
            conferir("pulsos", 32'(got), 32'(exp));
        end
    end

    initial begin
        tab[0]  = '{ESPERANDO,     5,  -1, 0};
        tab[1]  = '{PAGAMENTO,     6,  -1, 0};
        tab[2]  = '{PRESSURIZACAO, 5,   2, 4};
        tab[3]  = '{AQUECIMENTO,   9,   3, 8};
        tab[4]  = '{PRONTO,        5,   4, 4};
        tab[5]  = '{ESCOLHENDO,    4,  -1, 0};
        tab[6]  = '{ERRO_VALOR,    12,  1, 8};
        tab[7]  = '{SENSORES,      3,  -1, 0};
        tab[8]  = '{PAGAMENTO,     5,  -1, 0};
        tab[9]  = '{ESCOLHENDO,    3,  -1, 0};
        tab[10] = '{PAGAMENTO,     20,  0, 12};
        tab[11] = '{ESPERANDO,     4,  -1, 0};

        RST_N = 1'b0;
        bus.ESTADO_COD = ESPERANDO;
        repeat (3) @(negedge CLK);

        // Count in PAGAMENTO, then abort with an asynchronous reset.
        RST_N = 1'b1;
        bus.ESTADO_COD = PAGAMENTO;
        repeat (6) @(negedge CLK);
        conferir("ativo_antes_reset", 32'(bus.ATIVO), 32'd1);
        conferir("restante_antes_reset", 32'(bus.RESTANTE), 32'd2);
        #1 RST_N = 1'b0;
        #1;
        conferir("ativo_reset", 32'(bus.ATIVO), 32'd0);
        conferir("restante_reset", 32'(bus.RESTANTE), 32'd0);
        bus.ESTADO_COD = ESPERANDO;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (100) @(negedge CLK);
        conferir("ativo_ocioso", 32'(bus.ATIVO), 32'd0);
        conferir("restante_ocioso", 32'(bus.RESTANTE), 32'd0);

        // PAGAMENTO held: RESTANTE 3,2,1 then 0 at expiry; single pulse.
        @(negedge CLK);
        bus.ESTADO_COD = PAGAMENTO;
        e0 = edge_n + 1;
        fila.push_back('{0, e0 + 12});
        for (int k = 0; k <= 14; k++) begin
            @(posedge CLK);
            #1;
            conferir($sformatf("restante_k%0d", k), 32'(bus.RESTANTE), (k < 12) ? 32'(3 - k / PRESC) : 32'd0);
            conferir($sformatf("ativo_k%0d", k), 32'(bus.ATIVO), (k < 12) ? 32'd1 : 32'd0);
        end
        repeat (50) @(negedge CLK);

        for (int i = 0; i < 12; i++)
            aplicar(tab[i].cod, tab[i].hold, tab[i].linha, tab[i].atraso);

        // ERRO_VALOR left on exactly the expiry edge: no pulse, back to idle.
        aplicar(ERRO_VALOR, 8, -1, 0);
        conferir("ativo_erro_final", 32'(bus.ATIVO), 32'd1);
        conferir("restante_erro_final", 32'(bus.RESTANTE), 32'd1);
        aplicar(ESPERANDO, 2, -1, 0);
        conferir("ativo_pos_colisao", 32'(bus.ATIVO), 32'd0);
        conferir("restante_pos_colisao", 32'(bus.RESTANTE), 32'd0);
        repeat (20) @(negedge CLK);

        conferir("pulsos_pendentes", 32'(fila.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/temporizador_estados.md
Name: temporizador_estados

Overview:
- Timer generator for the coffee-machine controller; the other end of its TIMER_* interface.
- Watches the controller's registered state code (its SAIDA output).
- Counts time spent in each timed state and returns a single-cycle timeout pulse on the matching TIMER_* line.
- Also drives a remaining-time value for the display.

Parameters:
- PRESC, 50000000: CLK cycles per tick (1 s at 50 MHz).
- PRESC_W, 26: prescaler counter width.
- CNT_W, 6: tick counter width.
- T_PAG, 30: ticks allowed in PAGAMENTO.
- T_ERRO, 3: ticks in ERRO_VALOR.
- T_PRE, 5: ticks in PRESSURIZACAO.
- T_AQU, 10: ticks in AQUECIMENTO.
- T_PRO, 4: ticks in PRONTO.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- ESTADO_COD  input  3  state code from controller: 000 ESPERANDO, 001 ESCOLHENDO, 010 SENSORES, 011 PAGAMENTO, 100 ERRO_VALOR, 101 PRESSURIZACAO, 110 AQUECIMENTO, 111 PRONTO.
- TIMER_PAG  output  1  timeout pulse, state 011.
- TIMER_ERRO  output  1  timeout pulse, state 100.
- TIMER_PRE  output  1  timeout pulse, state 101.
- TIMER_AQU  output  1  timeout pulse, state 110.
- TIMER_PRO  output  1  timeout pulse, state 111.
- RESTANTE  output  CNT_W  ticks remaining in current timed state; 0 when untimed or expired.
- ATIVO  output  1  high while counting.

Behaviour:
- Reset is asynchronous, active-low. On reset:
  - All TIMER_* = 0, RESTANTE = 0, ATIVO = 0.
  - EST_REG = 000, prescaler = 0, tick counter = 0, FSM = OCIOSO.
- Every rising edge registers ESTADO_COD into EST_REG.
- A "change" is ESTADO_COD != EST_REG at an edge. On a change edge:
  - Prescaler and tick counter clear to 0.
  - FSM goes to CONTANDO if the new code is 011..111, else to OCIOSO.
  - The limit L is selected from the T_* parameter for that code. A parameter value of 0 is treated as 1.
- Internal FSM:
  - OCIOSO: no counting; ATIVO = 0; RESTANTE = 0; all pulses 0.
  - CONTANDO: prescaler increments each cycle and wraps at PRESC-1. On wrap the tick counter increments. ATIVO = 1. RESTANTE = L - tick counter.
  - When the tick counter is L-1 and the prescaler wraps: the matching TIMER_* is registered high for exactly one cycle and the FSM goes to EXPIRADO.
  - EXPIRADO: ATIVO = 0; RESTANTE = 0; no further pulses until a change occurs.
  - The controller ignoring a pulse never produces a repeat pulse.
- Latency: with the change captured at edge 0, the pulse is high in the cycle following edge L*PRESC.
- At most one TIMER_* is high in any cycle. All outputs are registered.
- A change on the same edge as expiry wins: no pulse, counters restart.
- Re-entering the same state code without passing through another code does not restart the count.
- A return to a timed state through another code restarts the count from 0.
- Reset asserted mid-count aborts immediately. The first edge after release with ESTADO_COD = 000 is not a change.
- All counters are unsigned. The tick counter saturates at L and never wraps.

Decomposition:
- Shared package holds:
  - State-code constants ESPERANDO..PRONTO (3-bit).
  - Internal FSM encodings OCIOSO = 2'b00, CONTANDO = 2'b01, EXPIRADO = 2'b10.
  - The controller uses the same state-code constants.
- One sub-module is natural: divisor_tick.
  - Prescaler with synchronous clear and enable; emits a one-cycle tick on wrap.
  - Ports CLK, RST_N, LIMPA, HABILITA, TICK; parameters PRESC, PRESC_W.

Test Plan (PRESC=4, T_PAG=3, T_ERRO=2, T_PRE=1, T_AQU=2, T_PRO=1):
- Reset low mid-count, then release, ESTADO_COD = 000 -> all outputs 0; no pulse for 100 cycles.
- ESTADO_COD 000 -> 011 held -> TIMER_PAG high exactly one cycle, 12 cycles after the change edge. RESTANTE steps 3, 2, 1, then 0 at expiry. No second pulse in the next 50 cycles.
- 011 held for 6 cycles, then 101 -> no TIMER_PAG; TIMER_PRE pulses 4 cycles after the 101 edge.
- Sequence 101 -> 110 -> 111, each changed on the cycle after its pulse -> pulses TIMER_PRE, TIMER_AQU, TIMER_PRO at +4, +8, +4 cycles respectively. Never two pulses in the same cycle.
- 100 held and changed to 000 on exactly the edge where expiry would fire -> TIMER_ERRO stays 0; FSM goes to OCIOSO.
- 011 -> 001 -> 011 -> the count restarts; TIMER_PAG fires 12 cycles after the second 011 edge.
